// File: rtl/gf2_mul_share_arb_if.sv
// Handshake bundle tying requesters, the response consumer and the shared
// GF(2^2) multiply cell to the sharing arbiter.
interface gf2_mul_share_arb_if #(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [3*NREQ-1:0] req_a;
   logic [3*NREQ-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_q;
   logic [IDW-1:0]    rsp_id;
   logic [2:0]        mul_a;
   logic [2:0]        mul_b;
   logic [1:0]        mul_q;

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_q,
      input  req_ready, rsp_valid, rsp_q, rsp_id, mul_a, mul_b
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_q,
      output req_ready, rsp_valid, rsp_q, rsp_id, mul_a, mul_b
   );
endinterface

// File: rtl/gf2_mul_share_arb.sv
// Round-robin sequencer sharing one GF(2^2) multiply-and-scale cell; the cell
// only sees operands during its single evaluation cycle and zeros otherwise.
module gf2_mul_share_arb #(
   parameter int NREQ       = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gf2_mul_share_arb_if.slave   bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = IDW + 1;
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, EVAL, RESP, GAP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [2:0]      op_a_q, op_a_d;
   logic [2:0]      op_b_q, op_b_d;
   logic [1:0]      rsp_data_q, rsp_data_d;
   logic [3:0]      gap_cnt_q, gap_cnt_d;

   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [CW-1:0]   cand;
   logic [2:0]      sel_a, sel_b;
   logic [NREQ-1:0] ready_vec;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + CW'(k);
         if (cand >= CW'(NREQ)) begin
            cand = cand - CW'(NREQ);
         end
         if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      sel_a     = '0;
      sel_b     = '0;
      ready_vec = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            sel_a = 3'(bus.req_a >> (3 * i));
            sel_b = 3'(bus.req_b >> (3 * i));
            ready_vec[i] = rst_n && (state_q == IDLE) && grant_found;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      id_d       = id_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      rsp_data_d = rsp_data_q;
      gap_cnt_d  = gap_cnt_q;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               op_a_d   = sel_a;
               op_b_d   = sel_b;
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
               state_d  = EVAL;
            end
         end
         // Operands are wiped as the product is captured so the cell idles at zero.
         EVAL: begin
            rsp_data_d = bus.mul_q;
            op_a_d     = '0;
            op_b_d     = '0;
            state_d    = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_data_d = '0;
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  gap_cnt_d = GAP_LOAD;
                  state_d   = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         id_q       <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         rsp_data_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         id_q       <= id_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         rsp_data_q <= rsp_data_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   // Operand registers are nonzero only during EVAL, so they drive the cell directly.
   assign bus.req_ready = ready_vec;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_q     = rsp_data_q;
   assign bus.rsp_id    = id_q;
   assign bus.mul_a     = op_a_q;
   assign bus.mul_b     = op_b_q;
endmodule
